cart_pipe: RTL

Parametrised, fully pipelined cartoonifier core. Accepts one 3x3 RGB pixel window per cycle under a valid/ready handshake and computes per-pixel intensity, Sobel gradient magnitude against a runtime threshold, and a smoothed centre pixel. It emits one filtered pixel per accepted window, selected by a per-window mode. It replaces the fixed 8-bit, fixed-threshold, enable-chained cartoon datapath and sits between the window buffer and the output frame writer.

---
 rtl/cart_pkg.sv | 33 +++
 rtl/cart_sobel.sv | 47 ++++
 rtl/cart_pipe.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cart_pkg.sv
// Shared types and helpers for the cartoonifier pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cart_pkg;

  // Per-window filter selection, travels with the window through the pipe.
  typedef enum logic [1:0] {
    CART_CARTOON = 2'd0,
    CART_EDGEMAP = 2'd1,
    CART_BLUR    = 2'd2,
    CART_PASS    = 2'd3
  } cart_mode_e;

  // 3x3 window geometry, pixels numbered row-major.
  localparam int NUM_PIX    = 9;
  localparam int NUM_CH     = 3;
  localparam int CENTRE_IDX = 4;

  // Widest channel the intensity helper handles; callers size-cast in and out.
  localparam int MAX_CH_W = 32;

  // Luma-like intensity (R + 2G + B) / 4; never exceeds the channel maximum.
  function automatic logic [MAX_CH_W-1:0] intensity(
    input logic [MAX_CH_W-1:0] r,
    input logic [MAX_CH_W-1:0] g,
    input logic [MAX_CH_W-1:0] b
  );
    logic [MAX_CH_W+1:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return MAX_CH_W'(sum >> 2);
  endfunction

endpackage

// File: rtl/cart_sobel.sv
// Combinational Sobel gradient magnitude |gx| + |gy| over nine intensities.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage register decides when to sample.
module cart_sobel
  import cart_pkg::*;
#(
  parameter int CH_W = 8
) (
  input  logic [NUM_PIX*CH_W-1:0] intens,
  output logic [CH_W+2:0]         mag
);

  // One weighted row/column sum a + 2m + c reaches 4*max, so CH_W+2 bits.
  localparam int SW = CH_W + 2;

  function automatic logic [SW-1:0] tri_sum(
    input logic [CH_W-1:0] a,
    input logic [CH_W-1:0] m,
    input logic [CH_W-1:0] c
  );
    return SW'(a) + (SW'(m) << 1) + SW'(c);
  endfunction

  function automatic logic [SW-1:0] abs_diff(
    input logic [SW-1:0] a,
    input logic [SW-1:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic [CH_W-1:0] i [NUM_PIX];
  logic [SW-1:0]   gx;
  logic [SW-1:0]   gy;

  // Unpack the flat intensity vector into per-pixel values.
  always_comb begin
    for (int k = 0; k < NUM_PIX; k++) begin
      i[k] = intens[k*CH_W +: CH_W];
    end
  end

  // Right column minus left column, bottom row minus top row.
  assign gx  = abs_diff(tri_sum(i[2], i[5], i[8]), tri_sum(i[0], i[3], i[6]));
  assign gy  = abs_diff(tri_sum(i[6], i[7], i[8]), tri_sum(i[0], i[1], i[2]));
  assign mag = (CH_W+3)'(gx) + (CH_W+3)'(gy);

endmodule

// File: rtl/cart_pipe.sv
// Three-stage cartoonifier: intensity/blur sums, Sobel magnitude, edge select.
// Latency: 3 cycles from acceptance to out_valid; one window per cycle.
// Backpressure: global stall, in_ready = !out_valid || out_ready. Macro CART_EDGE_CNT_EN builds the edge counter.
module cart_pipe
  import cart_pkg::*;
#(
  parameter int CH_W  = 8,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [27*CH_W-1:0]    in_window,
  input  logic [1:0]            in_mode,
  input  logic [CH_W+2:0]       in_thresh,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3*CH_W-1:0]     out_pixel,
  output logic                  out_edge,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      edge_count
);

  localparam int PIX_W = NUM_CH * CH_W;
  localparam int BS_W  = CH_W + 4;   // 16 * channel max fits
  localparam int MAG_W = CH_W + 3;

  // Whole pipe moves together; only the output register can hold it back.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1: intensities and blur sums ----------------
  logic [NUM_PIX*CH_W-1:0] int_d;
  logic [BS_W-1:0]         bsum_d [NUM_CH];

  logic                    s1_vld;
  logic [NUM_PIX*CH_W-1:0] s1_int;
  logic [BS_W-1:0]         s1_bsum [NUM_CH];
  logic [PIX_W-1:0]        s1_centre;
  cart_mode_e              s1_mode;
  logic [MAG_W-1:0]        s1_thresh;

  // Per-pixel intensity and per-channel weighted blur sum (centre weight 8).
  always_comb begin
    int_d = '0;
    for (int k = 0; k < NUM_PIX; k++) begin
      int_d[k*CH_W +: CH_W] = CH_W'(intensity(
        MAX_CH_W'(in_window[k*PIX_W + 2*CH_W +: CH_W]),
        MAX_CH_W'(in_window[k*PIX_W +   CH_W +: CH_W]),
        MAX_CH_W'(in_window[k*PIX_W          +: CH_W])));
    end
    for (int c = 0; c < NUM_CH; c++) begin
      bsum_d[c] = '0;
      for (int k = 0; k < NUM_PIX; k++) begin
        if (k == CENTRE_IDX) begin
          bsum_d[c] = bsum_d[c] + (BS_W'(in_window[k*PIX_W + c*CH_W +: CH_W]) << 3);
        end else begin
          bsum_d[c] = bsum_d[c] + BS_W'(in_window[k*PIX_W + c*CH_W +: CH_W]);
        end
      end
    end
  end

  // S1 valid: reset clears in-flight windows.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_vld <= 1'b0;
    end else if (adv) begin
      s1_vld <= in_valid;
    end
  end

  // S1 payload: mode and threshold are latched with the window they belong to.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_int    <= int_d;
      s1_bsum   <= bsum_d;
      s1_centre <= in_window[CENTRE_IDX*PIX_W +: PIX_W];
      s1_mode   <= cart_mode_e'(in_mode);
      s1_thresh <= in_thresh;
    end
  end

  // ---------------- S2: gradient magnitude ----------------
  logic [MAG_W-1:0] mag_d;

  cart_sobel #(
    .CH_W (CH_W)
  ) u_sobel (
    .intens (s1_int),
    .mag    (mag_d)
  );

  logic             s2_vld;
  logic [MAG_W-1:0] s2_mag;
  logic [BS_W-1:0]  s2_bsum [NUM_CH];
  logic [PIX_W-1:0] s2_centre;
  cart_mode_e       s2_mode;
  logic [MAG_W-1:0] s2_thresh;

  // S2 valid.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s2_vld <= 1'b0;
    end else if (adv) begin
      s2_vld <= s1_vld;
    end
  end

  // S2 payload.
  always_ff @(posedge clk) begin
    if (adv) begin
      s2_mag    <= mag_d;
      s2_bsum   <= s1_bsum;
      s2_centre <= s1_centre;
      s2_mode   <= s1_mode;
      s2_thresh <= s1_thresh;
    end
  end

  // ---------------- S3: edge decision and mode select ----------------
  logic             edge_d;
  logic [PIX_W-1:0] blur_px;
  logic [PIX_W-1:0] res_d;

  // Strict compare, then pick the output pixel for this window's mode.
  always_comb begin
    edge_d  = s2_mag > s2_thresh;
    blur_px = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      blur_px[c*CH_W +: CH_W] = CH_W'(s2_bsum[c] >> 4);
    end
    res_d = '0;
    case (s2_mode)
      CART_CARTOON: res_d = edge_d ? {PIX_W{1'b0}} : blur_px;
      CART_EDGEMAP: res_d = edge_d ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
      CART_BLUR:    res_d = blur_px;
      CART_PASS:    res_d = s2_centre;
      default:      res_d = s2_centre;
    endcase
  end

  // Output register; holds steady while downstream stalls.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_edge  <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_vld;
      out_pixel <= res_d;
      out_edge  <= edge_d;
    end
  end

  // ---------------- Edge counter ----------------
`ifdef CART_EDGE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count delivered edge pixels; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready && out_edge) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign edge_count = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign edge_count     = '0;
`endif

endmodule
